// File: rtl/seg_part_csa_pipe_acc_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-save segment summer.
// The csa_* functions describe the shape of the reduction tree level by level.
package seg_part_csa_pipe_acc_pkg;

    localparam int MAX_ROWS = 32;

    typedef struct packed {
        logic valid;
        logic mode;
        logic first;
        logic last;
    } sband_t;

    function automatic int res_w(input int w, input int rows, input int acc_w);
        return w + $clog2(rows) + acc_w;
    endfunction

    // Rows left after one level: groups of 7 become 3, leftover groups of 3 become 2.
    function automatic int csa_next(input int n);
        if (n <= 2) return n;
        return 3 * (n / 7) + 2 * ((n % 7) / 3) + (n % 7) % 3;
    endfunction

    function automatic int csa_rows_at(input int rows, input int lvl);
        int n;
        n = rows;
        for (int i = 0; i < lvl; i++) n = csa_next(n);
        return n;
    endfunction

    function automatic int csa_offset(input int rows, input int lvl);
        int off;
        off = 0;
        for (int i = 0; i < lvl; i++) off += csa_rows_at(rows, i);
        return off;
    endfunction

    function automatic int csa_levels(input int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = csa_next(n);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/seg_part_csa_pipe_acc_if.sv
// Row-beat input and result output channels of the segment summer, each valid/ready.
interface seg_part_csa_pipe_acc_if #(
    parameter int W     = 18,
    parameter int ROWS  = 10,
    parameter int RES_W = 30
);
    logic [ROWS*W-1:0] in_rows;
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic              in_first;
    logic              in_last;
    logic [RES_W-1:0]  out_result;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_rows, in_valid, in_mode, in_first, in_last, out_ready,
        input  in_ready, out_result, out_ovf, out_valid
    );

    modport slave (
        input  in_rows, in_valid, in_mode, in_first, in_last, out_ready,
        output in_ready, out_result, out_ovf, out_valid
    );
endinterface

// File: rtl/seg_part_csa_pipe_acc_csa.sv
// Combinational carry-save reduction of ROWS unsigned rows down to a sum/carry pair.
// Shifted-out bits are dropped; OUT_W must hold the full exact sum.
module compressor_3to2 #(
    parameter int N = 30
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] c_i,
    output logic [N-1:0] s_o,
    output logic [N-1:0] c_o
);
    logic [N-1:0] maj;

    assign s_o = a_i ^ b_i ^ c_i;
    assign maj = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign c_o = maj << 1;
endmodule

module compressor_7to3 #(
    parameter int N = 30
) (
    input  logic [N-1:0] x0_i,
    input  logic [N-1:0] x1_i,
    input  logic [N-1:0] x2_i,
    input  logic [N-1:0] x3_i,
    input  logic [N-1:0] x4_i,
    input  logic [N-1:0] x5_i,
    input  logic [N-1:0] x6_i,
    output logic [N-1:0] s_o,
    output logic [N-1:0] c_o,
    output logic [N-1:0] d_o
);
    logic [N-1:0] w1, w2, w4;

    always_comb begin
        w1 = '0;
        w2 = '0;
        w4 = '0;
        for (int i = 0; i < N; i++) begin
            {w4[i], w2[i], w1[i]} = 3'(x0_i[i]) + 3'(x1_i[i]) + 3'(x2_i[i]) + 3'(x3_i[i])
                                  + 3'(x4_i[i]) + 3'(x5_i[i]) + 3'(x6_i[i]);
        end
    end

    assign s_o = w1;
    assign c_o = w2 << 1;
    assign d_o = w4 << 2;
endmodule

module seg_csa_reduce
    import seg_part_csa_pipe_acc_pkg::*;
#(
    parameter int W     = 18,
    parameter int ROWS  = 10,
    parameter int OUT_W = 30
) (
    input  logic [ROWS*W-1:0] rows_i,
    output logic [OUT_W-1:0]  sum_o,
    output logic [OUT_W-1:0]  carry_o
);
    localparam int LEVELS = csa_levels(ROWS);
    localparam int TOTAL  = csa_offset(ROWS, LEVELS) + 2;

    if (ROWS < 3 || ROWS > MAX_ROWS) begin : g_bad_rows
        $error("seg_csa_reduce: ROWS out of range");
    end

    // All tree levels live in one flat array; level l starts at csa_offset(ROWS, l).
    logic [OUT_W-1:0] node [TOTAL];

    for (genvar k = 0; k < ROWS; k++) begin : g_in
        assign node[k] = OUT_W'(rows_i[k*W +: W]);
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int NP = csa_rows_at(ROWS, l - 1);
        localparam int IB = csa_offset(ROWS, l - 1);
        localparam int OB = csa_offset(ROWS, l);
        localparam int G7 = NP / 7;
        localparam int G3 = (NP % 7) / 3;
        localparam int RR = (NP % 7) % 3;

        for (genvar g = 0; g < G7; g++) begin : g_c7
            compressor_7to3 #(.N(OUT_W)) u_c7 (
                .x0_i(node[IB+7*g]),   .x1_i(node[IB+7*g+1]), .x2_i(node[IB+7*g+2]),
                .x3_i(node[IB+7*g+3]), .x4_i(node[IB+7*g+4]), .x5_i(node[IB+7*g+5]),
                .x6_i(node[IB+7*g+6]),
                .s_o(node[OB+3*g]), .c_o(node[OB+3*g+1]), .d_o(node[OB+3*g+2])
            );
        end
        for (genvar g = 0; g < G3; g++) begin : g_c3
            compressor_3to2 #(.N(OUT_W)) u_c3 (
                .a_i(node[IB+7*G7+3*g]), .b_i(node[IB+7*G7+3*g+1]), .c_i(node[IB+7*G7+3*g+2]),
                .s_o(node[OB+3*G7+2*g]), .c_o(node[OB+3*G7+2*g+1])
            );
        end
        for (genvar g = 0; g < RR; g++) begin : g_pass
            assign node[OB+3*G7+2*G3+g] = node[IB+7*G7+3*G3+g];
        end
    end

    assign sum_o   = node[TOTAL-2];
    assign carry_o = node[TOTAL-1];
endmodule

// File: rtl/seg_part_csa_pipe_acc.sv
// Three-stage valid/ready pipeline summing ROWS rows per beat, with optional group accumulate.
// Any output stall freezes every stage, bubbles included.
module seg_part_csa_pipe_acc
    import seg_part_csa_pipe_acc_pkg::*;
#(
    parameter int W     = 18,
    parameter int ROWS  = 10,
    parameter int ACC_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    seg_part_csa_pipe_acc_if.slave bus
);
    localparam int RES_W = res_w(W, ROWS, ACC_W);

    sband_t           s1_sb_q, s2_sb_q;
    logic [RES_W-1:0] s1_sum_q, s1_car_q, s2_sum_q;
    logic [RES_W-1:0] acc_q, acc_d, out_result_q, out_result_d;
    logic             acc_ovf_q, acc_ovf_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;
    logic [RES_W-1:0] csa_sum, csa_car;
    logic [RES_W:0]   acc_sum;
    logic             stall;

    seg_csa_reduce #(.W(W), .ROWS(ROWS), .OUT_W(RES_W)) u_csa (
        .rows_i (bus.in_rows),
        .sum_o  (csa_sum),
        .carry_o(csa_car)
    );

    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = !stall && !rst;
    assign acc_sum      = {1'b0, acc_q} + {1'b0, s2_sum_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sb_q  <= '0;
            s2_sb_q  <= '0;
            s1_sum_q <= '0;
            s1_car_q <= '0;
            s2_sum_q <= '0;
        end else if (!stall) begin
            s1_sb_q  <= '{valid: bus.in_valid, mode: bus.in_mode,
                          first: bus.in_first, last: bus.in_last};
            s1_sum_q <= csa_sum;
            s1_car_q <= csa_car;
            s2_sb_q  <= s1_sb_q;
            s2_sum_q <= s1_sum_q + s1_car_q;
        end
    end

    // A pass beat leaves the open group's accumulator alone.
    always_comb begin
        acc_d        = acc_q;
        acc_ovf_d    = acc_ovf_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        out_valid_d  = stall;
        if (!stall && s2_sb_q.valid) begin
            if (!s2_sb_q.mode) begin
                out_result_d = s2_sum_q;
                out_ovf_d    = 1'b0;
                out_valid_d  = 1'b1;
            end else begin
                if (s2_sb_q.first) begin
                    acc_d     = s2_sum_q;
                    acc_ovf_d = 1'b0;
                end else begin
                    acc_d     = acc_sum[RES_W-1:0];
                    acc_ovf_d = acc_ovf_q | acc_sum[RES_W];
                end
                if (s2_sb_q.last) begin
                    out_result_d = acc_d;
                    out_ovf_d    = acc_ovf_d;
                    out_valid_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            acc_ovf_q    <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_ovf_q    <= acc_ovf_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.out_result = out_result_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_seg_part_csa_pipe_acc.sv
// Bench for seg_part_csa_pipe_acc: directed group/backpressure/reset cases plus random traffic,
// all scored against a queue model of row sums and group totals.
module tb_seg_part_csa_pipe_acc;
    import seg_part_csa_pipe_acc_pkg::*;

    localparam int W     = 18;
    localparam int ROWS  = 10;
    localparam int ACC_W = 8;
    localparam int RES_W = res_w(W, ROWS, ACC_W);
    localparam longint unsigned MODV = 64'd1 << RES_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    seg_part_csa_pipe_acc_if #(.W(W), .ROWS(ROWS), .RES_W(RES_W)) bus ();
    seg_part_csa_pipe_acc #(.W(W), .ROWS(ROWS), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    function automatic void chk(input string name, input longint unsigned act,
                                input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic logic [ROWS*W-1:0] fill_rows(input int v);
        logic [ROWS*W-1:0] r;
        for (int k = 0; k < ROWS; k++) r[k*W +: W] = W'(v);
        return r;
    endfunction

    function automatic longint unsigned row_sum(input logic [ROWS*W-1:0] r);
        longint unsigned s;
        s = 0;
        for (int k = 0; k < ROWS; k++) s += 64'(r[k*W +: W]);
        return s;
    endfunction

    // out_ready has a single driver: random, or a forced level
    bit rand_ready = 1'b0;
    bit ready_force = 1'b1;
    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Reference model and compare process
    longint unsigned exp_res[$];
    bit              exp_ovf[$];
    longint unsigned seen_res[$];
    bit              seen_ovf[$];
    longint unsigned m_acc = 0;
    bit              m_ovf = 1'b0;
    bit              prev_stall = 1'b0;
    logic [RES_W-1:0] prev_res = '0;
    logic            prev_ovf = 1'b0;
    int              last_acc_cyc = 0;
    int              last_out_cyc = 0;

    always @(negedge clk) begin
        longint unsigned s;
        if (rst) begin
            exp_res.delete();
            exp_ovf.delete();
            m_acc = 0;
            m_ovf = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", 64'(bus.out_valid), 1);
                chk("stall_hold_result", 64'(bus.out_result), 64'(prev_res));
                chk("stall_hold_ovf", 64'(bus.out_ovf), 64'(prev_ovf));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0d expected=none", bus.out_result);
                end else begin
                    chk("result", 64'(bus.out_result), exp_res.pop_front());
                    chk("ovf", 64'(bus.out_ovf), 64'(exp_ovf.pop_front()));
                end
                seen_res.push_back(64'(bus.out_result));
                seen_ovf.push_back(bus.out_ovf);
                last_out_cyc = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.out_result;
            prev_ovf   = bus.out_ovf;
            if (bus.in_valid && bus.in_ready) begin
                s = row_sum(bus.in_rows);
                last_acc_cyc = cyc;
                if (!bus.in_mode) begin
                    exp_res.push_back(s);
                    exp_ovf.push_back(1'b0);
                end else begin
                    if (bus.in_first) begin
                        m_acc = s;
                        m_ovf = 1'b0;
                    end else begin
                        m_acc = m_acc + s;
                        if (m_acc >= MODV) begin
                            m_acc = m_acc - MODV;
                            m_ovf = 1'b1;
                        end
                    end
                    if (bus.in_last) begin
                        exp_res.push_back(m_acc);
                        exp_ovf.push_back(m_ovf);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ROWS*W-1:0] rows, input bit mode, input bit first,
                        input bit last);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        bus.in_rows  = rows;
        bus.in_mode  = mode;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            done = bus.in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int t;
        t = 0;
        while (seen_res.size() < n && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (seen_res.size() < n) begin
            failures++;
            $display("FAIL wait_outs actual=%0d expected=%0d", seen_res.size(), n);
        end
    endtask

    task automatic clear_seen();
        seen_res.delete();
        seen_ovf.delete();
    endtask

    // Parameter sweep instances, pass mode with random valid/ready
    bit sweep_done [2];
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SR  = (g == 0) ? 3 : 32;
        localparam int SRW = res_w(8, SR, 8);
        logic srst = 1'b1;
        longint unsigned sq[$];

        seg_part_csa_pipe_acc_if #(.W(8), .ROWS(SR), .RES_W(SRW)) sbus ();
        seg_part_csa_pipe_acc #(.W(8), .ROWS(SR), .ACC_W(8)) u_dut (
            .clk(clk), .rst(srst), .bus(sbus)
        );

        always @(negedge clk) begin
            longint unsigned s;
            if (!srst) begin
                if (sbus.out_valid && sbus.out_ready) begin
                    if (sq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sweep_rows%0d_unexpected actual=%0d expected=none",
                                 SR, sbus.out_result);
                    end else begin
                        chk($sformatf("sweep_rows%0d_result", SR), 64'(sbus.out_result),
                            sq.pop_front());
                    end
                end
                if (sbus.in_valid && sbus.in_ready) begin
                    s = 0;
                    for (int k = 0; k < SR; k++) s += 64'(sbus.in_rows[k*8 +: 8]);
                    sq.push_back(s);
                end
            end
        end

        initial begin
            bit took;
            took = 1'b0;
            sbus.in_valid  = 1'b0;
            sbus.in_rows   = '0;
            sbus.in_mode   = 1'b0;
            sbus.in_first  = 1'b0;
            sbus.in_last   = 1'b0;
            sbus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            srst = 1'b0;
            for (int c = 0; c < 600; c++) begin
                if (!sbus.in_valid || took) begin
                    sbus.in_valid = ($urandom_range(0, 2) != 0);
                    for (int k = 0; k < SR; k++) sbus.in_rows[k*8 +: 8] = 8'($urandom);
                end
                sbus.out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                took = sbus.in_valid && sbus.in_ready;
                @(posedge clk);
                #1;
            end
            sbus.in_valid  = 1'b0;
            sbus.out_ready = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            chk($sformatf("sweep_rows%0d_drain", SR), 64'(sq.size()), 0);
            sweep_done[g] = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROWS*W-1:0] all1;
        logic [ROWS*W-1:0] r;
        int t;
        all1 = fill_rows(32'h3FFFF);
        bus.in_valid = 1'b0;
        bus.in_rows  = '0;
        bus.in_mode  = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;

        // Reset state
        tick(2);
        @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 0);
        chk("reset_out_valid", 64'(bus.out_valid), 0);
        chk("reset_out_result", 64'(bus.out_result), 0);
        chk("reset_out_ovf", 64'(bus.out_ovf), 0);
        tick(1);
        rst = 1'b0;

        // Pass mode, all ones
        clear_seen();
        send(all1, 1'b0, 1'b0, 1'b0);
        wait_outs(1);
        chk("pass_latency", 64'(last_out_cyc - last_acc_cyc), 3);
        chk("pass_result", seen_res[0], 2621430);
        chk("pass_ovf", 64'(seen_ovf[0]), 0);

        // Backpressure
        ready_force = 1'b0;
        tick(1);
        clear_seen();
        fork
            begin
                for (int k = 1; k <= 4; k++) send(fill_rows(k), 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", 64'(bus.in_ready), 0);
                chk("bp_no_output_yet", 64'(seen_res.size()), 0);
                ready_force = 1'b1;
            end
        join
        wait_outs(4);
        tick(5);
        chk("bp_count", 64'(seen_res.size()), 4);
        for (int i = 0; i < 4; i++) chk("bp_order", seen_res[i], 64'(10 * (i + 1)));

        // Accumulate, four beats
        clear_seen();
        send(all1, 1'b1, 1'b1, 1'b0);
        send(all1, 1'b1, 1'b0, 1'b0);
        send(all1, 1'b1, 1'b0, 1'b0);
        send(all1, 1'b1, 1'b0, 1'b1);
        wait_outs(1);
        tick(4);
        chk("acc_count", 64'(seen_res.size()), 1);
        chk("acc_result", seen_res[0], 10485720);
        chk("acc_ovf", 64'(seen_ovf[0]), 0);

        // Overflow group, then a fresh single-beat group
        clear_seen();
        for (int i = 0; i < 410; i++) send(all1, 1'b1, i == 0, i == 409);
        wait_outs(1);
        chk("ovf_result", seen_res[0], 1044476);
        chk("ovf_flag", 64'(seen_ovf[0]), 1);
        clear_seen();
        send(all1, 1'b1, 1'b1, 1'b1);
        wait_outs(1);
        chk("ovf_clear_result", seen_res[0], 2621430);
        chk("ovf_clear_flag", 64'(seen_ovf[0]), 0);

        // Reset in the middle of a group
        clear_seen();
        send(all1, 1'b1, 1'b1, 1'b0);
        send(all1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        send(fill_rows(1), 1'b1, 1'b1, 1'b1);
        wait_outs(1);
        tick(5);
        chk("rst_mid_count", 64'(seen_res.size()), 1);
        chk("rst_mid_result", seen_res[0], 10);
        chk("rst_mid_ovf", 64'(seen_ovf[0]), 0);

        // Random mixed traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < ROWS; k++) r[k*W +: W] = W'($urandom);
            send(r, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        tick(12);
        chk("drain_empty", 64'(exp_res.size()), 0);

        t = 0;
        while (!(sweep_done[0] && sweep_done[1]) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (!(sweep_done[0] && sweep_done[1])) begin
            failures++;
            $display("FAIL sweep_timeout actual=unfinished expected=finished");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
